// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
// Contents: FSM state encoding, latency counter width, full-word read-enable value.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         LAT_W    = 4;
    localparam logic [3:0] REN_WORD = 4'hF;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous byte-enable word RAM with registered read port
// Ports: clk; we[3:0] byte-lane write enables; waddr/wdata write port;
//        raddr/re read port; rdata registered read data (holds when re=0).
module dmem_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              re,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(2**ADDR_W)-1];

    // No reset anywhere here so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/daccess_dmem_responder.sv
// rtl/daccess_dmem_responder.sv - CPU data-access responder with programmable latency
// Ports: cpu_clk/cpu_rst (async, active-high); daccess_ren/addr/wen/wdata request in;
//        daccess_valid/rdata load response; daccess_wresp store response;
//        busy (WAIT or RESP); overrun (sticky, request seen while not IDLE).
module daccess_dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [3:0]  daccess_ren,
    input  logic [31:0] daccess_addr,
    input  logic [3:0]  daccess_wen,
    input  logic [31:0] daccess_wdata,
    output logic        daccess_valid,
    output logic [31:0] daccess_rdata,
    output logic        daccess_wresp,
    output logic        busy,
    output logic        overrun
);

    localparam logic [32:0] SPAN = 33'd4 << ADDR_W;
    localparam bit          LAT1 = (LATENCY == 1);

    state_t              state;
    logic [LAT_W-1:0]    cnt;
    logic                is_write;
    logic [ADDR_W-1:0]   cap_idx;
    logic                cap_in;
    logic                rd_zero;

    logic                req;
    logic                wr_req;
    logic [31:0]         off;
    logic [ADDR_W-1:0]   idx;
    logic                in_range;
    logic                accept;

    logic [3:0]          arr_we;
    logic                rd_fire;
    logic [ADDR_W-1:0]   rd_idx;
    logic [31:0]         arr_rdata;

    assign req      = (|daccess_ren) | (|daccess_wen);
    assign wr_req   = |daccess_wen;
    assign off      = daccess_addr - BASE_ADDR;
    assign idx      = off[ADDR_W+1:2];
    assign in_range = {1'b0, off} < SPAN;
    assign accept   = (state == IDLE) && req && !cpu_rst;

    // Stores commit at the capture edge; out-of-range stores are simply dropped.
    assign arr_we = (accept && wr_req && in_range) ? daccess_wen : 4'b0000;

    // The array is read on the edge that moves the FSM into RESP. With a
    // latency of one that is the capture edge itself, so the live address is used.
    always_comb begin
        rd_fire = 1'b0;
        rd_idx  = cap_idx;
        if (LAT1 && accept && !wr_req) begin
            rd_fire = in_range;
            rd_idx  = idx;
        end else if (state == WAIT && cnt == LAT_W'(1) && !is_write) begin
            rd_fire = cap_in;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (cpu_clk),
        .we     (arr_we),
        .waddr  (idx),
        .wdata  (daccess_wdata),
        .raddr  (rd_idx),
        .re     (rd_fire),
        .rdata  (arr_rdata)
    );

    // rd_zero masks the un-reset RAM output after reset and for out-of-range loads.
    assign daccess_rdata = rd_zero ? 32'h0 : arr_rdata;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            is_write      <= 1'b0;
            cap_idx       <= '0;
            cap_in        <= 1'b0;
            rd_zero       <= 1'b1;
            daccess_valid <= 1'b0;
            daccess_wresp <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            daccess_valid <= 1'b0;
            daccess_wresp <= 1'b0;
            if (req && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        is_write <= wr_req;
                        cap_idx  <= idx;
                        cap_in   <= in_range;
                        cnt      <= LAT_W'(LATENCY - 1);
                        busy     <= 1'b1;
                        if (LAT1) begin
                            state         <= RESP;
                            daccess_valid <= !wr_req;
                            daccess_wresp <= wr_req;
                            if (!wr_req) begin
                                rd_zero <= !in_range;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - LAT_W'(1);
                    if (cnt == LAT_W'(1)) begin
                        state         <= RESP;
                        daccess_valid <= !is_write;
                        daccess_wresp <= is_write;
                        if (!is_write) begin
                            rd_zero <= !cap_in;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_daccess_dmem_responder.sv
// tb/tb_daccess_dmem_responder.sv - scoreboard bench for the data-memory responder
module tb_daccess_dmem_responder;

    logic        clk;
    logic        rst1, rst2;
    logic [3:0]  ren, wen;
    logic [31:0] addr, wdata;

    logic        v1, w1, b1, o1;
    logic [31:0] rd1;
    logic        v2, w2, b2, o2;
    logic [31:0] rd2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [31:0] rd;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    logic [31:0] m1[int];
    logic [31:0] m2[int];
    logic [31:0] last_rd2;

    daccess_dmem_responder #(.ADDR_W(12), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
        .cpu_clk(clk), .cpu_rst(rst1), .daccess_ren(ren), .daccess_addr(addr),
        .daccess_wen(wen), .daccess_wdata(wdata), .daccess_valid(v1),
        .daccess_rdata(rd1), .daccess_wresp(w1), .busy(b1), .overrun(o1));

    daccess_dmem_responder #(.ADDR_W(12), .LATENCY(2), .BASE_ADDR(32'h0)) dut2 (
        .cpu_clk(clk), .cpu_rst(rst2), .daccess_ren(ren), .daccess_addr(addr),
        .daccess_wen(wen), .daccess_wdata(wdata), .daccess_valid(v2),
        .daccess_rdata(rd2), .daccess_wresp(w2), .busy(b2), .overrun(o2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitors: every pulse must match the head of its scoreboard.
    always @(negedge clk) begin
        if (v1 || w1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL d1_unexpected cyc=%0d valid=%b wresp=%b", cyc, v1, w1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (cyc !== e.cyc || w1 !== e.wr || v1 !== !e.wr || (!e.wr && rd1 !== e.rd)) begin
                    n_err++;
                    $display("FAIL d1_resp got cyc=%0d v=%b w=%b rd=%h want cyc=%0d wr=%b rd=%h",
                             cyc, v1, w1, rd1, e.cyc, e.wr, e.rd);
                end
            end
        end
        if (v2 || w2) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL d2_unexpected cyc=%0d valid=%b wresp=%b", cyc, v2, w2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                if (cyc !== e.cyc || w2 !== e.wr || v2 !== !e.wr || (!e.wr && rd2 !== e.rd)) begin
                    n_err++;
                    $display("FAIL d2_resp got cyc=%0d v=%b w=%b rd=%h want cyc=%0d wr=%b rd=%h",
                             cyc, v2, w2, rd2, e.cyc, e.wr, e.rd);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle request; when push is set the expected response is queued from the model.
    task automatic send(input int d, input logic [3:0] r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] wd, input bit push);
        exp_t e;
        int   lat;
        int   wi;
        bit   inr;
        logic [31:0] word;
        lat = (d == 1) ? 1 : 2;
        inr = (a < 32'h4000);
        wi  = int'(a >> 2);
        ren = r; wen = w; addr = a; wdata = wd;
        if (push) begin
            e.cyc = cyc + lat;
            e.wr  = (w != 4'h0);
            e.rd  = 32'h0;
            if (e.wr) begin
                if (inr) begin
                    word = (d == 1) ? (m1.exists(wi) ? m1[wi] : 32'h0)
                                    : (m2.exists(wi) ? m2[wi] : 32'h0);
                    for (int i = 0; i < 4; i++)
                        if (w[i]) word[8*i +: 8] = wd[8*i +: 8];
                    if (d == 1) m1[wi] = word; else m2[wi] = word;
                end
            end else if (inr) begin
                e.rd = (d == 1) ? m1[wi] : m2[wi];
            end
            if (!e.wr && d == 2) last_rd2 = e.rd;
            if (d == 1) q1.push_back(e); else q2.push_back(e);
        end
        tick(1);
        ren = 4'h0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) tick(1);
        n_cmp++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_resp got pending d1=%0d d2=%0d want 0", name, q1.size(), q2.size());
        end
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++;
        if ({v1, w1, b1, o1, rd1} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_d1 got v=%b w=%b b=%b o=%b rd=%h want all 0", v1, w1, b1, o1, rd1);
        end
        n_cmp++;
        if ({v2, w2, b2, o2, rd2} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_d2 got v=%b w=%b b=%b o=%b rd=%h want all 0", v2, w2, b2, o2, rd2);
        end
        rst2 = 1'b0;
        tick(2);
        n_cmp++;
        if ({v2, w2, b2, o2, rd2} !== 36'h0) begin
            n_err++;
            $display("FAIL post_reset_d2 got v=%b w=%b b=%b o=%b rd=%h want all 0", v2, w2, b2, o2, rd2);
        end
    endtask

    task automatic test_store_load();
        n_cmp++;
        if (b2 !== 1'b0) begin n_err++; $display("FAIL busy_T got %b want 0", b2); end
        send(2, 4'h0, 4'hF, 32'h10, 32'hDEADBEEF, 1);
        n_cmp++;
        if (b2 !== 1'b1) begin n_err++; $display("FAIL busy_T1 got %b want 1", b2); end
        tick(1);
        n_cmp++;
        if (b2 !== 1'b1) begin n_err++; $display("FAIL busy_T2 got %b want 1", b2); end
        tick(1);
        n_cmp++;
        if (b2 !== 1'b0) begin n_err++; $display("FAIL busy_T3 got %b want 0", b2); end
        send(2, dmem_pkg::REN_WORD, 4'h0, 32'h10, 32'h0, 1);
        tick(2);
        drain("store_load");
    endtask

    task automatic test_byte_lanes();
        send(2, 4'h0, 4'b0100, 32'h12, 32'h00AA0000, 1);
        tick(2);
        send(2, 4'hF, 4'h0, 32'h10, 32'h0, 1);
        tick(2);
        drain("byte_lanes");
        n_cmp++;
        if (rd2 !== 32'hDEAABEEF) begin
            n_err++;
            $display("FAIL byte_lane_data got %h want deaabeef", rd2);
        end
    endtask

    task automatic test_out_of_range();
        send(2, 4'h0, 4'hF, 32'h0, 32'hCAFEF00D, 1);
        tick(2);
        send(2, 4'hF, 4'h0, 32'h4000, 32'h0, 1);
        tick(2);
        send(2, 4'h0, 4'hF, 32'h4000, 32'h12345678, 1);
        tick(2);
        n_cmp++;
        if (rd2 !== last_rd2) begin
            n_err++;
            $display("FAIL rdata_hold got %h want %h", rd2, last_rd2);
        end
        send(2, 4'hF, 4'h0, 32'h0, 32'h0, 1);
        tick(2);
        drain("out_of_range");
    endtask

    task automatic test_simultaneous();
        send(2, 4'hF, 4'hF, 32'h20, 32'h11223344, 1);
        tick(2);
        send(2, 4'hF, 4'h0, 32'h20, 32'h0, 1);
        tick(2);
        drain("simultaneous");
    endtask

    task automatic test_reset_in_wait();
        send(2, 4'hF, 4'h0, 32'h10, 32'h0, 0);
        rst2 = 1'b1;
        #1;
        n_cmp++;
        if ({v2, w2, b2, o2, rd2} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_in_wait got v=%b w=%b b=%b o=%b rd=%h want all 0", v2, w2, b2, o2, rd2);
        end
        tick(1);
        rst2 = 1'b0;
        tick(5);
        send(2, 4'hF, 4'h0, 32'h10, 32'h0, 1);
        tick(2);
        drain("reset_in_wait");
    endtask

    task automatic test_latency1();
        rst2 = 1'b1;
        rst1 = 1'b0;
        tick(2);
        send(1, 4'h0, 4'hF, 32'h40, 32'hA5A5_0001, 1);
        tick(1);
        send(1, 4'hF, 4'h0, 32'h40, 32'h0, 1);
        tick(1);
        send(1, 4'h0, 4'hF, 32'h44, 32'h5A5A_0002, 1);
        tick(1);
        send(1, 4'hF, 4'h0, 32'h44, 32'h0, 1);
        tick(1);
        drain("lat1_b2b");
        n_cmp++;
        if (o1 !== 1'b0) begin n_err++; $display("FAIL lat1_no_overrun got %b want 0", o1); end
        send(1, 4'hF, 4'h0, 32'h40, 32'h0, 1);
        send(1, 4'hF, 4'h0, 32'h44, 32'h0, 0);
        tick(1);
        n_cmp++;
        if (o1 !== 1'b1) begin n_err++; $display("FAIL lat1_overrun got %b want 1", o1); end
        send(1, 4'hF, 4'h0, 32'h44, 32'h0, 1);
        tick(3);
        drain("lat1_overrun");
        n_cmp++;
        if (o1 !== 1'b1) begin n_err++; $display("FAIL overrun_sticky got %b want 1", o1); end
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        ren = 4'h0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        last_rd2 = 32'h0;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_out_of_range();
        test_simultaneous();
        test_reset_in_wait();
        test_latency1();
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/daccess_dmem_responder.md
Name: daccess_dmem_responder

Overview:
Responder side of the CPU Data Access Interface. It accepts single-word load/store requests from the core's MEM stage and performs them on an internal byte-writable word array. After a programmable latency it returns exactly one response pulse per request: daccess_valid with read data for loads, daccess_wresp for stores. It sits beside the core in the SoC/testbench top as the data memory behind the ldst_suspend stall mechanism.

Parameters:
ADDR_W, 12, word-address bits; array depth = 2**ADDR_W words (16 KiB at default).
LATENCY, 2, cycles from request capture to response pulse; legal range 1..15.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
cpu_clk  input  1  clock, all state on rising edge
cpu_rst  input  1  asynchronous reset, active-high
daccess_ren  input  4  read request, 4'hF when a load is issued; any nonzero value counts as a read request
daccess_addr  input  32  byte address of the request
daccess_wen  input  4  byte-lane write enables; nonzero means a store request
daccess_wdata  input  32  store data, lane-aligned
daccess_valid  output  1  one-cycle read-response pulse
daccess_rdata  output  32  full word read; valid in the daccess_valid cycle
daccess_wresp  output  1  one-cycle write-response pulse
busy  output  1  high in WAIT and RESP
overrun  output  1  sticky; set when a request arrives while not IDLE

Behaviour:
- Reset (async, cpu_rst=1): state=IDLE, counter=0, daccess_valid=0, daccess_wresp=0, daccess_rdata=0, busy=0, overrun=0. Array contents are not cleared. A request in flight is discarded and gets no response.
- Request detection: req = (|daccess_ren) | (|daccess_wen). A request is accepted only in IDLE. It is captured at the rising edge that ends the request cycle T. Captured fields: addr, wen, wdata, and is_write = |wen. Write takes priority if ren and wen are both nonzero; only daccess_wresp is then returned.
- Address decode: off = addr - BASE_ADDR; word index = off[ADDR_W+1:2]. The request is in range iff off < 4*2**ADDR_W. Address bits [1:0] are ignored; the core extracts bytes and halfwords itself.
- Store: committed to the array at the capture edge. Only lanes with wen[i]=1 are written, with wdata[8i+7:8i]. An out-of-range store is dropped but still answered with wresp.
- Load: the array is read at the edge ending cycle T+LATENCY-1 and registered into daccess_rdata. An out-of-range load returns 32'h0. daccess_rdata holds its value until the next load response; stores do not change it.
- FSM:
  - IDLE: req -> counter=LATENCY-1, then RESP if LATENCY==1, else WAIT.
  - WAIT: counter decrements each cycle; counter==1 -> RESP.
  - RESP: for exactly one cycle (T+LATENCY), daccess_valid=!is_write and daccess_wresp=is_write. Then -> IDLE.
- Throughput: one request per LATENCY+1 cycles. A request present in any non-IDLE cycle (including RESP) is ignored and sets overrun. Requests are one-cycle pulses by protocol.
- daccess_valid and daccess_wresp are never both high, and are never high outside RESP.
- Read-after-write: a load accepted after a store's wresp observes the stored data.

Decomposition:
- Package dmem_pkg holds:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Counter width constant LAT_W=4.
  - Full-word read-enable constant REN_WORD=4'hF.
- Sub-module dmem_array: synchronous byte-enable word RAM. Ports: clk, we[3:0], waddr, wdata, raddr, re, rdata (registered). It has no reset, so it can infer block RAM.
- FSM, counter, range check and overrun stay in the top module.

Test Plan:
- LATENCY=2; store wen=4'hF, addr=0x10, wdata=0xDEADBEEF in cycle T -> wresp=1 only in T+2, busy high in T+1..T+2. Then load ren=4'hF, addr=0x10 -> valid=1 exactly 2 cycles later, rdata=0xDEADBEEF.
- Byte lanes: store wen=4'b0100, addr=0x12, wdata=0x00AA0000 over 0xDEADBEEF at 0x10 -> later load at 0x10 returns 0xDEAABEEF.
- LATENCY=1: back-to-back requests spaced 2 cycles -> each answered in the following cycle, overrun stays 0. A second request in the RESP cycle -> ignored, no extra pulse, overrun=1 and sticky.
- Out-of-range: load at BASE_ADDR+0x4000 (ADDR_W=12) -> valid pulse with rdata=0. Store there -> wresp pulse, array word 0 unchanged.
- Simultaneous ren=4'hF and wen=4'hF -> write performed, only wresp pulses, valid stays 0.
- Assert cpu_rst in a WAIT cycle of a load -> all outputs 0 immediately, no response after release, and the next request is served normally.
